// File: rtl/lutram_pkg.sv
// -----------------------------------------------------------------------------
// lutram_pkg
// Shared sizing constants for the 64-deep distributed-RAM FIFO.
//   DEPTH  : number of FIFO entries (one per LUT RAM address)
//   ADDR_W : RAM address / pointer width
//   CNT_W  : occupancy counter width, wide enough to hold 0..DEPTH
// -----------------------------------------------------------------------------
package lutram_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 7;

endpackage : lutram_pkg

// File: rtl/lutram_fifo64_ram64x1d.sv
// -----------------------------------------------------------------------------
// lutram_fifo64_ram64x1d
// Behavioural model of a 64x1 dual-port distributed RAM primitive: one
// synchronous write port and two asynchronous read ports.
// Ports:
//   WCLK  in   write clock (rising edge)
//   WE    in   write strobe
//   A     in   6-bit read/write address (write port + single-port read)
//   D     in   write data bit
//   DPRA  in   6-bit dual-port read address
//   SPO   out  asynchronous read of mem[A]
//   DPO   out  asynchronous read of mem[DPRA]
// The array has no reset, exactly like the hardware LUT RAM.
// -----------------------------------------------------------------------------
module lutram_fifo64_ram64x1d
    import lutram_pkg::*;
(
    input  logic              WCLK,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A,
    input  logic              D,
    input  logic [ADDR_W-1:0] DPRA,
    output logic              SPO,
    output logic              DPO
);

    logic [DEPTH-1:0] mem_q;

    always_ff @(posedge WCLK) begin
        if (WE) begin
            mem_q[A] <= D;
        end
    end

    assign SPO = mem_q[A];
    assign DPO = mem_q[DPRA];

endmodule : lutram_fifo64_ram64x1d

// File: rtl/lutram_fifo64.sv
// -----------------------------------------------------------------------------
// lutram_fifo64
// 64-entry synchronous FIFO in standard (non-FWFT) read mode, built from
// WIDTH slices of a 64x1 dual-port distributed RAM.
// Parameters:
//   WIDTH               data width, 1..64
//   ALMOST_FULL_OFFSET  ALMOST_FULL  when COUNT >= 64 - offset, 1..63
//   ALMOST_EMPTY_OFFSET ALMOST_EMPTY when COUNT <= offset, 1..63
//   DO_INIT             value of DO after reset
// Ports:
//   CLK           in   clock, rising edge
//   RST           in   synchronous active-high reset (flushes the FIFO)
//   WE / DI       in   write request / write data
//   RE            in   read request
//   DO            out  registered read data, valid the cycle after an accepted RE
//   FULL, EMPTY   out  64 / 0 entries stored
//   ALMOST_FULL   out  see ALMOST_FULL_OFFSET
//   ALMOST_EMPTY  out  see ALMOST_EMPTY_OFFSET
//   COUNT         out  occupancy 0..64
//   WRERR, RDERR  out  one-cycle pulses for rejected write / read
// -----------------------------------------------------------------------------
module lutram_fifo64
    import lutram_pkg::*;
#(
    parameter int               WIDTH               = 8,
    parameter int               ALMOST_FULL_OFFSET  = 4,
    parameter int               ALMOST_EMPTY_OFFSET = 4,
    parameter logic [WIDTH-1:0] DO_INIT             = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [WIDTH-1:0] DI,
    input  logic             RE,
    output logic [WIDTH-1:0] DO,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic [CNT_W-1:0] COUNT,
    output logic             WRERR,
    output logic             RDERR
);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [CNT_W-1:0] CNT_AEMPT = CNT_W'(ALMOST_EMPTY_OFFSET);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              full_q,   full_d;
    logic              empty_q,  empty_d;
    logic              afull_q,  afull_d;
    logic              aempty_q, aempty_d;
    logic              wrerr_q,  wrerr_d;
    logic              rderr_q,  rderr_d;
    logic [WIDTH-1:0]  do_q,     do_d;

    logic              wr_acc;
    logic              rd_acc;
    logic [WIDTH-1:0]  ram_dpo;
    logic [WIDTH-1:0]  ram_spo_unused;

    // Accept decisions use last cycle's registered flags, so a full FIFO
    // can still take a write in the same cycle only via the read freeing a
    // slot on the following edge -- never within the same edge.
    assign wr_acc = WE & ~full_q;
    assign rd_acc = RE & ~empty_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_slice
            lutram_fifo64_ram64x1d u_ram (
                .WCLK (CLK),
                .WE   (wr_acc),
                .A    (wr_ptr_q),
                .D    (DI[gi]),
                .DPRA (rd_ptr_q),
                .SPO  (ram_spo_unused[gi]),
                .DPO  (ram_dpo[gi])
            );
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_d     = do_q;

        // Pointers wrap naturally at 64; fullness comes from count_q only.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            do_d     = ram_dpo;
        end

        count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

        // Flags are computed from the next count so they are exact right
        // after the edge rather than one cycle late.
        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CNT_AFULL);
        aempty_d = (count_d <= CNT_AEMPT);

        wrerr_d  = WE & full_q;
        rderr_d  = RE & empty_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            wrerr_q  <= 1'b0;
            rderr_q  <= 1'b0;
            do_q     <= DO_INIT;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            wrerr_q  <= wrerr_d;
            rderr_q  <= rderr_d;
            do_q     <= do_d;
        end
    end

    assign DO           = do_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign COUNT        = count_q;
    assign WRERR        = wrerr_q;
    assign RDERR        = rderr_q;

endmodule : lutram_fifo64

// File: tb/tb_lutram_fifo64.sv
// -----------------------------------------------------------------------------
// tb_lutram_fifo64
// Self-checking bench for lutram_fifo64 (default parameters). A queue-based
// reference model tracks the FIFO contents; every output is compared after
// every clock edge.
// -----------------------------------------------------------------------------
module tb_lutram_fifo64;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       WE  = 1'b0;
    logic       RE  = 1'b0;
    logic [7:0] DI  = '0;
    logic [7:0] DO;
    logic       FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, WRERR, RDERR;
    logic [6:0] COUNT;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] exp_do;
    logic       exp_wrerr;
    logic       exp_rderr;

    lutram_fifo64 dut (
        .CLK          (CLK),
        .RST          (RST),
        .WE           (WE),
        .DI           (DI),
        .RE           (RE),
        .DO           (DO),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .WRERR        (WRERR),
        .RDERR        (RDERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check("DO",           32'(DO),           32'(exp_do));
        check("COUNT",        32'(COUNT),        32'(n));
        check("FULL",         32'(FULL),         32'(n == 64));
        check("EMPTY",        32'(EMPTY),        32'(n == 0));
        check("ALMOST_FULL",  32'(ALMOST_FULL),  32'(n >= 60));
        check("ALMOST_EMPTY", 32'(ALMOST_EMPTY), 32'(n <= 4));
        check("WRERR",        32'(WRERR),        32'(exp_wrerr));
        check("RDERR",        32'(RDERR),        32'(exp_rderr));
    endtask

    // One clock with the given requests; model updated from pre-edge state.
    task automatic step(input logic we, input logic re, input logic [7:0] di);
        int  n;
        WE = we; RE = re; DI = di;
        @(posedge CLK);
        n = mq.size();
        exp_wrerr = we && (n == 64);
        exp_rderr = re && (n == 0);
        if (re && n != 0) exp_do = mq.pop_front();
        if (we && n != 64) mq.push_back(di);
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic we, input logic re);
        RST = 1'b1; WE = we; RE = re; DI = 8'h77;
        @(posedge CLK);
        mq.delete();
        exp_do = 8'h00;
        exp_wrerr = 1'b0;
        exp_rderr = 1'b0;
        #1;
        check_all();
        RST = 1'b0;
    endtask

    initial begin
        // Reset then idle
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00);

        // Fill 0x00..0x3F
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 8'(i));
        // Overflow: 0xAA must be dropped
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 8'h00);
        // Drain 64 words
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'h00);
        // Underflow: DO must hold
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Simultaneous RE+WE at COUNT=10
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);

        // Simultaneous at EMPTY, then read back the written word
        step(1'b1, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h00);

        // Simultaneous at FULL
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b1, 8'h00);

        // Pointer wrap: 32 resident, 200 interleaved write+read pairs
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 8'($urandom));

        // Random traffic, biased phases to reach both boundaries
        for (int i = 0; i < 400; i++) begin
            if (i < 200) step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 8'($urandom));
            else         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        // Reset mid-operation at COUNT=37 with both requests high
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 8'h00);
        do_reset(1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h5C);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("DO_5C", 32'(DO), 32'h5C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lutram_fifo64

// File: doc/lutram_fifo64.md
Name: lutram_fifo64

Overview:
- 64-entry synchronous FIFO, WIDTH bits wide, built on distributed LUT RAM: WIDTH bit-slices of a 64x1 dual-port RAM.
- Sits directly on top of the dual-port RAM primitive and drives it:
  - write pointer to the read/write address port (A), write data to D, write strobe to WE;
  - read pointer to the dual-port read address (DPRA);
  - consumes the asynchronous dual-port output (DPO) into a registered data output.
- Standard (non-FWFT) read mode with Xilinx-style status and error flags, for Verilator simulation and synthesis alike.

Parameters:
- WIDTH, 8, data width in bits; one RAM slice per bit; legal range 1..64.
- ALMOST_FULL_OFFSET, 4, ALMOST_FULL asserted when COUNT >= 64 - ALMOST_FULL_OFFSET; legal range 1..63.
- ALMOST_EMPTY_OFFSET, 4, ALMOST_EMPTY asserted when COUNT <= ALMOST_EMPTY_OFFSET; legal range 1..63.
- DO_INIT, {WIDTH{1'b0}}, value loaded into DO at reset.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- WE  input  1  write request.
- DI  input  WIDTH  write data.
- RE  input  1  read request.
- DO  output  WIDTH  registered read data.
- FULL  output  1  64 entries stored.
- EMPTY  output  1  0 entries stored.
- ALMOST_FULL  output  1  see parameter.
- ALMOST_EMPTY  output  1  see parameter.
- COUNT  output  7  occupancy, 0..64.
- WRERR  output  1  one-cycle pulse: write rejected.
- RDERR  output  1  one-cycle pulse: read rejected.

Behaviour:
- Clocking and reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset values (RST high at a CLK edge):
  - wr_ptr = 0, rd_ptr = 0, COUNT = 0, EMPTY = 1, FULL = 0;
  - ALMOST_EMPTY = 1, ALMOST_FULL = 0, WRERR = 0, RDERR = 0, DO = DO_INIT.
  - WE and RE are ignored in the reset cycle, so a reset mid-operation flushes the FIFO.
  - RAM contents are not cleared; they are unobservable until rewritten.
- Accept conditions, evaluated on the registered flags at the start of the cycle:
  - wr_acc = WE & ~FULL;
  - rd_acc = RE & ~EMPTY.
- Write: on wr_acc, the RAM write strobe is asserted with A = wr_ptr and D = DI; wr_ptr increments mod 64 (6-bit natural wrap).
- Read:
  - DPRA = rd_ptr at all times;
  - on rd_acc, DO <= DPO (the word at rd_ptr) and rd_ptr increments mod 64;
  - read latency: DO is valid the cycle after the accepted RE;
  - DO holds its value when no read is accepted.
- Occupancy:
  - COUNT <= COUNT + wr_acc - rd_acc, in 7-bit arithmetic, never outside 0..64;
  - all flags are registered and derived from next COUNT, so they are exact in the cycle after the edge.
- Simultaneous events:
  - WE and RE when 0 < COUNT < 64: both accepted, COUNT unchanged.
  - WE and RE when FULL: read accepted, write rejected, WRERR pulses, COUNT becomes 63.
  - WE and RE when EMPTY: write accepted, read rejected, RDERR pulses, COUNT becomes 1. There is no bypass: the written word is readable from the next cycle.
  - Read and write to the same RAM address in one cycle can only occur when COUNT is 0 or 64, and in both cases one side is rejected. No read-during-write hazard is reachable.
- Errors:
  - WRERR = 1 for exactly one cycle after an edge with WE & FULL;
  - RDERR = 1 for exactly one cycle after an edge with RE & EMPTY;
  - the FIFO state is unchanged by a rejected request.
- Pointer wrap: after 64 writes, wr_ptr returns to 0. The occupancy counter disambiguates full from empty; pointer equality alone is never used.

Decomposition:
- Shared package/include lutram_pkg: localparam DEPTH = 64, localparam ADDR_W = 6, localparam CNT_W = 7.
- Sub-module: the existing 64x1 dual-port RAM primitive, instantiated WIDTH times in a generate loop, one per data bit.
  - Shared connections: WCLK = CLK, WE = wr_acc, A = wr_ptr, DPRA = rd_ptr.
  - Per-slice connections: D = DI[i], DPO to the DO register input.
  - SPO is left unused.
- No other sub-modules; the control logic is flat.

Test Plan:
- Reset then idle: after RST for 1 cycle -> EMPTY=1, FULL=0, COUNT=0, ALMOST_EMPTY=1, DO=DO_INIT, no error pulses.
- Fill and drain: write 0x00..0x3F (64 writes) -> FULL=1 and COUNT=64 after the 64th edge, ALMOST_FULL from COUNT=60; then 64 reads -> DO = 0x00..0x3F in order, each one cycle after its RE; EMPTY=1 at end.
- Overflow/underflow: at FULL, WE=1 with DI=0xAA -> WRERR pulses 1 cycle, COUNT stays 64, 0xAA never read; at EMPTY, RE=1 -> RDERR pulses, DO unchanged.
- Simultaneous RE+WE: at COUNT=10 -> COUNT stays 10 for 20 cycles, output order preserved; at FULL -> COUNT=63, WRERR=1; at EMPTY -> COUNT=1, RDERR=1, next RE returns the written word.
- Pointer wrap: with 32 words resident, stream 200 writes and 200 reads interleaved -> data order intact across multiple 63->0 wraps, COUNT always within 0..64.
- Reset mid-operation: COUNT=37 with WE=RE=1 during the RST cycle -> next cycle COUNT=0, EMPTY=1, DO=DO_INIT; a subsequent write/read of 0x5C returns 0x5C.
